// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared types and constants for the AXI-Lite master: the
//               transaction state encoding and the AXI response codes.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    // Transaction sequencer states; one transaction in flight at a time.
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } axil_state_e;

    // AXI response codes, passed through to the command side untouched.
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_master
// Description : Single-outstanding AXI-Lite master. Converts a simple
//               valid/ready command (read or write) into AXI-Lite channel
//               traffic and returns one completion per command.
// Ports       : clk, rst_n            - clock, async active-low reset
//               cmd_*                 - command in (valid/ready, write flag,
//                                       address, write data, write strobes)
//               rsp_*                 - completion out (valid/ready, write
//                                       flag, read data, AXI response)
//               m_axil_aw*/w*/b*      - AXI-Lite write channels
//               m_axil_ar*/r*         - AXI-Lite read channels
// Revision    : 1.0 - initial release
// ============================================================================
module axil_master
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    // completion side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    // AW channel
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    // W channel
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    // B channel
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    // AR channel
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    // R channel
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    // ------------------------------------------------------------------------
    // State and output registers. Every output is a flop; the combinational
    // block below only computes next values.
    // ------------------------------------------------------------------------
    axil_state_e           r_state,      w_state_nxt;
    logic                  r_cmd_ready,  w_cmd_ready_nxt;
    logic                  r_awvalid,    w_awvalid_nxt;
    logic                  r_wvalid,     w_wvalid_nxt;
    logic                  r_bready,     w_bready_nxt;
    logic                  r_arvalid,    w_arvalid_nxt;
    logic                  r_rready,     w_rready_nxt;
    logic                  r_rsp_valid,  w_rsp_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,       w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,      w_wdata_nxt;
    logic [STRB_WIDTH-1:0] r_wstrb,      w_wstrb_nxt;
    logic                  r_rsp_write,  w_rsp_write_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata,  w_rsp_rdata_nxt;
    logic [1:0]            r_rsp_resp,   w_rsp_resp_nxt;

    // A write channel counts as done once its valid has dropped, or when it
    // handshakes in the current cycle. AW and W may finish in either order.
    logic w_aw_done;
    logic w_w_done;
    assign w_aw_done = !r_awvalid || m_axil_awready;
    assign w_w_done  = !r_wvalid  || m_axil_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= c_RESP_OKAY;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_rsp_write_nxt = r_rsp_write;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;

        case (r_state)
            IDLE: begin
                // cmd_ready comes up on the first edge after reset release.
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_addr_nxt      = cmd_addr;
                    w_wdata_nxt     = cmd_wdata;
                    w_wstrb_nxt     = cmd_wstrb;
                    if (cmd_write) begin
                        w_state_nxt   = WR_ADDR_DATA;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end

            WR_ADDR_DATA: begin
                // Each valid drops independently after its own handshake.
                w_awvalid_nxt = r_awvalid && !m_axil_awready;
                w_wvalid_nxt  = r_wvalid  && !m_axil_wready;
                if (w_aw_done && w_w_done) begin
                    w_state_nxt  = WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end

            WR_RESP: begin
                if (m_axil_bvalid) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_write_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = m_axil_bresp;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end
            end

            RD_ADDR: begin
                if (m_axil_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (m_axil_rvalid) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_write_nxt = 1'b0;
                    w_rsp_rdata_nxt = m_axil_rdata;
                    w_rsp_resp_nxt  = m_axil_rresp;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready      = r_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_write      = r_rsp_write;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_resp       = r_rsp_resp;
    assign m_axil_awaddr  = r_addr;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_addr;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule : axil_master
`default_nettype wire

// File: tb/tb_axil_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_master
// Description : Self-checking bench for axil_master with a behavioural
//               AXI-Lite RAM slave (8 x 32-bit words, byte strobes,
//               programmable AW stall and response codes). Expected
//               completions are queued at issue time and popped by an
//               independent completion monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_master;

    localparam int c_DW = 32;
    localparam int c_AW = 5;
    localparam int c_SW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_write = 1'b0;
    logic [c_AW-1:0] cmd_addr = '0;
    logic [c_DW-1:0] cmd_wdata = '0;
    logic [c_SW-1:0] cmd_wstrb = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic            rsp_write;
    logic [c_DW-1:0] rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [c_AW-1:0] awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [c_DW-1:0] wdata;
    logic [c_SW-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [c_AW-1:0] araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [c_DW-1:0] rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    always #5 clk = ~clk;

    axil_master #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .STRB_WIDTH(c_SW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    // ------------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural AXI-Lite RAM slave
    // ------------------------------------------------------------------------
    logic [31:0] mem [0:7];
    int          aw_delay = 0;     // cycles awready stays low while awvalid is high
    logic        ar_block = 1'b0;  // hold arready low
    logic [1:0]  b_code = 2'b00;
    logic [1:0]  r_code = 2'b00;
    int          aw_cnt = 0;
    int          b_hs_cnt = 0;
    logic        got_aw = 1'b0;
    logic        got_w = 1'b0;
    logic [2:0]  aw_idx_q = '0;
    logic [31:0] wdata_q = '0;
    logic [3:0]  wstrb_q = '0;

    assign awready = (aw_cnt >= aw_delay);
    assign wready  = 1'b1;
    assign arready = !ar_block;

    logic        s_a_ok, s_w_ok;
    logic [2:0]  s_idx;
    logic [31:0] s_data;
    logic [3:0]  s_strb;
    assign s_a_ok = got_aw || (awvalid && awready);
    assign s_w_ok = got_w  || (wvalid && wready);
    assign s_idx  = got_aw ? aw_idx_q : awaddr[4:2];
    assign s_data = got_w  ? wdata_q  : wdata;
    assign s_strb = got_w  ? wstrb_q  : wstrb;

    always @(posedge clk) begin
        if (!rst_n) begin
            bvalid <= 1'b0;
            bresp  <= 2'b00;
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
            got_aw <= 1'b0;
            got_w  <= 1'b0;
            aw_cnt <= 0;
        end else begin
            if (awvalid && !awready)     aw_cnt <= aw_cnt + 1;
            else if (awvalid && awready) aw_cnt <= 0;

            if (bvalid && bready) begin
                bvalid   <= 1'b0;
                b_hs_cnt <= b_hs_cnt + 1;
            end
            if (s_a_ok && s_w_ok && !bvalid) begin
                for (int i = 0; i < 4; i++)
                    if (s_strb[i]) mem[s_idx][8*i +: 8] <= s_data[8*i +: 8];
                bvalid <= 1'b1;
                bresp  <= b_code;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end else begin
                if (awvalid && awready) begin
                    got_aw   <= 1'b1;
                    aw_idx_q <= awaddr[4:2];
                end
                if (wvalid && wready) begin
                    got_w   <= 1'b1;
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                end
            end

            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[4:2]];
                rresp  <= r_code;
            end
        end
    end

    // Channel activity counters sampled mid-cycle.
    int aw_hi_cnt = 0;
    int w_hi_cnt  = 0;
    always @(negedge clk) begin
        if (awvalid) aw_hi_cnt <= aw_hi_cnt + 1;
        if (wvalid)  w_hi_cnt  <= w_hi_cnt + 1;
    end

    // ------------------------------------------------------------------------
    // Scoreboard: expected completions queued at issue, checked on handshake
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(input logic wr, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        e.wr = wr; e.data = data; e.resp = resp;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_write", {63'd0, rsp_write}, {63'd0, e.wr});
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.data});
                check("rsp_resp",  {62'd0, rsp_resp},  {62'd0, e.resp});
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (entered and left at posedge + #1)
    // ------------------------------------------------------------------------
    task automatic issue(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("cmd_accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) return;
        end
        check("rsp_timeout", 64'd1, 64'd0);
    endtask

    task automatic txn(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input exp_t e, input bit chk_lat);
        int lat;
        exp_q.push_back(e);
        issue(wr, addr, data, strb);
        wait_rsp(lat);
        if (chk_lat) check(wr ? "write_latency" : "read_latency", 64'(lat), 64'd3);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int lat;
        int base_aw, base_w, base_b, nvalid;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_awvalid",   {63'd0, awvalid},   64'd0);
        check("reset_wvalid",    {63'd0, wvalid},    64'd0);
        check("reset_bready",    {63'd0, bready},    64'd0);
        check("reset_arvalid",   {63'd0, arvalid},   64'd0);
        check("reset_rready",    {63'd0, rready},    64'd0);
        check("reset_rsp_resp",  {62'd0, rsp_resp},  64'd0);
        check("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check("reset_awaddr",    {59'd0, awaddr},    64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("awprot", {61'd0, awprot}, 64'd0);
        check("arprot", {61'd0, arprot}, 64'd0);
        @(posedge clk);
        #1;

        // Basic write / read-back with minimum latency
        txn(1'b1, 5'd1, 32'd2345, 4'hF, mk(1'b1, 32'd0, 2'b00), 1'b1);
        txn(1'b0, 5'd1, 32'd0,    4'h0, mk(1'b0, 32'd2345, 2'b00), 1'b1);

        // Partial strobe merge
        txn(1'b1, 5'd2, 32'h1111_2222, 4'hF,    mk(1'b1, 32'd0, 2'b00), 1'b1);
        txn(1'b1, 5'd2, 32'hAAAA_BBBB, 4'b0011, mk(1'b1, 32'd0, 2'b00), 1'b1);
        txn(1'b0, 5'd2, 32'd0,         4'h0,    mk(1'b0, 32'h1111_BBBB, 2'b00), 1'b1);

        // Error responses complete normally and pass through unchanged
        b_code = 2'b10;
        txn(1'b1, 5'd8, 32'hDEAD_BEEF, 4'hF, mk(1'b1, 32'd0, 2'b10), 1'b1);
        b_code = 2'b01;
        txn(1'b1, 5'd9, 32'h0000_00EF, 4'b0001, mk(1'b1, 32'd0, 2'b01), 1'b1);
        b_code = 2'b00;
        r_code = 2'b11;
        txn(1'b0, 5'd8, 32'd0, 4'h0, mk(1'b0, 32'hDEAD_BEEF, 2'b11), 1'b1);
        r_code = 2'b00;

        // AW stalled 3 cycles, W ready immediately
        aw_delay = 3;
        base_aw = aw_hi_cnt; base_w = w_hi_cnt; base_b = b_hs_cnt;
        txn(1'b1, 5'd12, 32'h1234_5678, 4'hF, mk(1'b1, 32'd0, 2'b00), 1'b0);
        check("awvalid_cycles", 64'(aw_hi_cnt - base_aw), 64'd4);
        check("wvalid_cycles",  64'(w_hi_cnt - base_w),   64'd1);
        check("b_handshakes",   64'(b_hs_cnt - base_b),   64'd1);
        aw_delay = 0;

        // Completion back-pressure: payload stable, no new command accepted
        rsp_ready = 1'b0;
        exp_q.push_back(mk(1'b0, 32'h1234_5678, 2'b00));
        issue(1'b0, 5'd12, 32'd0, 4'h0);
        wait_rsp(lat);
        exp_q.push_back(mk(1'b0, 32'h1111_BBBB, 2'b00));
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd1;
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("stall_rsp_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
            check("stall_rsp_resp",  {62'd0, rsp_resp},  64'd0);
            check("stall_rsp_write", {63'd0, rsp_write}, 64'd0);
            check("stall_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        issue(1'b0, 5'd1, 32'd0, 4'h0);
        wait_rsp(lat);
        check("post_stall_read_latency", 64'(lat), 64'd3);
        @(posedge clk);
        #1;

        // Reset while a read address is outstanding
        ar_block = 1'b1;
        issue(1'b0, 5'd4, 32'd0, 4'h0);
        @(negedge clk);
        check("arvalid_before_reset", {63'd0, arvalid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arvalid_async_reset", {63'd0, arvalid}, 64'd0);
        check("cmd_ready_in_reset",  {63'd0, cmd_ready}, 64'd0);
        check("rready_in_reset",     {63'd0, rready}, 64'd0);
        ar_block = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("cmd_ready_after_reset", {63'd0, cmd_ready}, 64'd1);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) nvalid++;
        end
        check("no_rsp_after_abort", 64'(nvalid), 64'd0);
        @(posedge clk);
        #1;

        // Normal operation resumes after the aborted transaction
        txn(1'b0, 5'd1, 32'd0, 4'h0, mk(1'b0, 32'h1111_BBBB, 2'b00), 1'b1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_axil_master
`default_nettype wire
